// File: rtl/alu_resp_checker.sv
// Response checker for a 74181 ALU under sweep test.
// Models expected outputs, compares one cycle later, keeps counters.
module alu_resp_checker #(
  parameter int EXP_TXN = 16384,
  parameter int CNT_W   = 16
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             start,
  input  logic             abort,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [3:0]       s,
  input  logic [3:0]       a,
  input  logic [3:0]       b,
  input  logic             cn,
  input  logic             m,
  input  logic [3:0]       f,
  input  logic             a_eq_b,
  input  logic             cn_4,
  output logic             busy,
  output logic             done,
  output logic             pass,
  output logic [CNT_W-1:0] txn_cnt,
  output logic [CNT_W-1:0] err_cnt,
  output logic [19:0]      fail_vec
);

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    RUN  = 2'd1,
    DONE = 2'd2
  } state_t;

  state_t state, state_nx;

  logic       xfer, last, clr;
  logic [3:0] x, y, lo;
  logic [4:0] sum;
  logic [3:0] f_exp;
  logic       eq_exp, c4_exp;

  logic       v1;
  logic [3:0] r_s, r_a, r_b, r_f, e_f;
  logic       r_cn, r_m, r_eq, r_c4;
  logic       e_eq, e_c4;
  logic       mism;

  assign in_ready = (state == RUN);
  assign xfer     = in_valid & in_ready;
  assign last     = xfer & (txn_cnt == CNT_W'(EXP_TXN - 1));
  assign clr      = start & ~abort & (state != RUN);

  // Active-high 74181 model: operand pair for arithmetic, logic result
  always_comb begin
    x  = 4'h0;
    y  = 4'h0;
    lo = 4'h0;
    unique case (s)
      4'h0: begin x = a;      y = 4'h0;   lo = ~a;       end
      4'h1: begin x = a | b;  y = 4'h0;   lo = ~(a | b); end
      4'h2: begin x = a | ~b; y = 4'h0;   lo = ~a & b;   end
      4'h3: begin x = 4'hF;   y = 4'h0;   lo = 4'h0;     end
      4'h4: begin x = a;      y = a & ~b; lo = ~(a & b); end
      4'h5: begin x = a | b;  y = a & ~b; lo = ~b;       end
      4'h6: begin x = a;      y = ~b;     lo = a ^ b;    end
      4'h7: begin x = a & ~b; y = 4'hF;   lo = a & ~b;   end
      4'h8: begin x = a;      y = a & b;  lo = ~a | b;   end
      4'h9: begin x = a;      y = b;      lo = ~(a ^ b); end
      4'hA: begin x = a | ~b; y = a & b;  lo = b;        end
      4'hB: begin x = a & b;  y = 4'hF;   lo = a & b;    end
      4'hC: begin x = a;      y = a;      lo = 4'hF;     end
      4'hD: begin x = a | b;  y = a;      lo = a | ~b;   end
      4'hE: begin x = a | ~b; y = a;      lo = a | b;    end
      4'hF: begin x = a;      y = 4'hF;   lo = a;        end
      default: begin x = 4'h0; y = 4'h0; lo = 4'h0; end
    endcase
    sum    = {1'b0, x} + {1'b0, y} + {4'b0, ~cn};
    f_exp  = m ? lo : sum[3:0];
    c4_exp = ~sum[4];
    eq_exp = (f_exp == 4'hF);
  end

  // Stage-1 mismatch; carry-out only meaningful in arithmetic mode
  assign mism = v1 & ((r_f != e_f) | (r_eq != e_eq) |
                      (~r_m & (r_c4 != e_c4)));

  // State register
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) state <= IDLE;
    else        state <= state_nx;
  end

  // Next state: abort beats start, start ignored while running
  always_comb begin
    state_nx = state;
    case (state)
      IDLE:    if (start && !abort) state_nx = RUN;
      RUN:     if (abort || last)   state_nx = DONE;
      DONE:    if (start && !abort) state_nx = RUN;
      default: state_nx = IDLE;
    endcase
  end

  // Stage 0 capture of stimulus, observed and expected outputs
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_s  <= '0; r_a  <= '0; r_b  <= '0;
      r_cn <= 1'b0; r_m <= 1'b0;
      r_f  <= '0; r_eq <= 1'b0; r_c4 <= 1'b0;
      e_f  <= '0; e_eq <= 1'b0; e_c4 <= 1'b0;
    end else if (xfer) begin
      r_s  <= s; r_a <= a; r_b <= b;
      r_cn <= cn; r_m <= m;
      r_f  <= f; r_eq <= a_eq_b; r_c4 <= cn_4;
      e_f  <= f_exp; e_eq <= eq_exp; e_c4 <= c4_exp;
    end
  end

  // Counters, in-flight flag and first-failure capture
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      v1       <= 1'b0;
      txn_cnt  <= '0;
      err_cnt  <= '0;
      fail_vec <= '0;
    end else if (clr) begin
      v1       <= 1'b0;
      txn_cnt  <= '0;
      err_cnt  <= '0;
      fail_vec <= '0;
    end else begin
      v1 <= xfer;
      if (xfer) txn_cnt <= txn_cnt + 1'b1;
      if (mism) begin
        if (err_cnt != '1) err_cnt <= err_cnt + 1'b1;
        if (err_cnt == '0)
          fail_vec <= {r_s, r_m, r_cn, r_a, r_b,
                       r_f, r_eq, r_c4};
      end
    end
  end

  assign busy = (state == RUN) | v1;
  assign done = (state == DONE) & ~v1;
  assign pass = done & (err_cnt == '0);

endmodule

// File: tb/tb_alu_resp_checker.sv
// Bench for alu_resp_checker: directed steps plus random and
// full-sweep traffic scored against an arithmetic 74181 model.
module tb_alu_resp_checker;

  logic        clk = 1'b0;
  logic        rst_n, start, abort, in_valid, in_ready;
  logic [3:0]  s, a, b, f;
  logic        cn, m, a_eq_b, cn_4;
  logic        busy, done, pass;
  logic [15:0] txn_cnt, err_cnt;
  logic [19:0] fail_vec;

  int          checks = 0;
  int          errors = 0;
  int          m_txn, m_err;
  logic [19:0] m_fail;

  always #5 clk = ~clk;

  alu_resp_checker #(.EXP_TXN(16384), .CNT_W(16)) dut (
    .clk(clk), .rst_n(rst_n), .start(start), .abort(abort),
    .in_valid(in_valid), .in_ready(in_ready),
    .s(s), .a(a), .b(b), .cn(cn), .m(m),
    .f(f), .a_eq_b(a_eq_b), .cn_4(cn_4),
    .busy(busy), .done(done), .pass(pass),
    .txn_cnt(txn_cnt), .err_cnt(err_cnt), .fail_vec(fail_vec)
  );

  // {f, a_eq_b, cn_4} from the data-book function table
  function automatic logic [5:0] ref181(input int vs, va, vb,
                                        input int vcn, vm);
    int na, nb, c, x, y, r, sum, c4;
    na = 15 - va;
    nb = 15 - vb;
    c  = 1 - vcn;
    r  = 0;
    c4 = 1;
    if (vm != 0) begin
      case (vs)
        0:  r = na;
        1:  r = 15 - (va | vb);
        2:  r = na & vb;
        3:  r = 0;
        4:  r = 15 - (va & vb);
        5:  r = nb;
        6:  r = va ^ vb;
        7:  r = va & nb;
        8:  r = na | vb;
        9:  r = 15 - (va ^ vb);
        10: r = vb;
        11: r = va & vb;
        12: r = 15;
        13: r = va | nb;
        14: r = va | vb;
        default: r = va;
      endcase
    end else begin
      case (vs)
        0:  begin x = va;        y = 0;        end
        1:  begin x = va | vb;   y = 0;        end
        2:  begin x = va | nb;   y = 0;        end
        3:  begin x = 15;        y = 0;        end
        4:  begin x = va;        y = va & nb;  end
        5:  begin x = va | vb;   y = va & nb;  end
        6:  begin x = va;        y = nb;       end
        7:  begin x = va & nb;   y = 15;       end
        8:  begin x = va;        y = va & vb;  end
        9:  begin x = va;        y = vb;       end
        10: begin x = va | nb;   y = va & vb;  end
        11: begin x = va & vb;   y = 15;       end
        12: begin x = va;        y = va;       end
        13: begin x = va | vb;   y = va;       end
        14: begin x = va | nb;   y = va;       end
        default: begin x = va;   y = 15;       end
      endcase
      sum = x + y + c;
      r   = sum % 16;
      c4  = (sum >= 16) ? 0 : 1;
    end
    return {4'(r), (r == 15), 1'(c4)};
  endfunction

  task automatic chk(input string tag,
                     input logic [31:0] obs, exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic model_clear();
    m_txn  = 0;
    m_err  = 0;
    m_fail = '0;
  endtask

  // One offered sample; model scores it only if the DUT was ready
  task automatic xfer(input int vs, va, vb, vcn, vm,
                      input bit bad);
    logic [5:0] e, o;
    logic       rdy;
    bit         mis;
    @(negedge clk);
    e = ref181(vs, va, vb, vcn, vm);
    o = bad ? (e ^ 6'($urandom_range(1, 63))) : e;
    s = 4'(vs); a = 4'(va); b = 4'(vb);
    cn = 1'(vcn); m = 1'(vm);
    f = o[5:2]; a_eq_b = o[1]; cn_4 = o[0];
    in_valid = 1'b1;
    rdy = in_ready;
    @(posedge clk);
    if (rdy) begin
      m_txn++;
      mis = (o[5:1] != e[5:1]) || (vm == 0 && o[0] != e[0]);
      if (mis) begin
        if (m_err == 0)
          m_fail = {4'(vs), 1'(vm), 1'(vcn),
                    4'(va), 4'(vb), o};
        if (m_err < 65535) m_err++;
      end
    end
  endtask

  task automatic drain();
    @(negedge clk);
    in_valid = 1'b0;
    @(negedge clk);
    @(negedge clk);
  endtask

  task automatic go();
    @(negedge clk);
    in_valid = 1'b0;
    start = 1'b1;
    @(negedge clk);
    start = 1'b0;
    model_clear();
  endtask

  task automatic do_abort();
    @(negedge clk);
    in_valid = 1'b0;
    abort = 1'b1;
    @(negedge clk);
    abort = 1'b0;
  endtask

  task automatic wait_done(input string tag);
    for (int i = 0; i < 20 && !done; i++) @(negedge clk);
    chk(tag, 32'(done), 32'd1);
  endtask

  task automatic chk_model(input string tag);
    chk({tag, "_txn"}, 32'(txn_cnt), 32'(m_txn));
    chk({tag, "_err"}, 32'(err_cnt), 32'(m_err));
    chk({tag, "_vec"}, 32'(fail_vec), 32'(m_fail));
  endtask

  initial begin
    rst_n = 1'b0; start = 1'b0; abort = 1'b0;
    in_valid = 1'b0;
    s = '0; a = '0; b = '0; cn = 1'b0; m = 1'b0;
    f = '0; a_eq_b = 1'b0; cn_4 = 1'b0;
    model_clear();
    repeat (3) @(negedge clk);
    chk("rst_ready", 32'(in_ready), 32'd0);
    chk("rst_busy", 32'(busy), 32'd0);
    chk("rst_done", 32'(done), 32'd0);
    chk("rst_pass", 32'(pass), 32'd0);
    chk("rst_txn", 32'(txn_cnt), 32'd0);
    chk("rst_err", 32'(err_cnt), 32'd0);
    chk("rst_vec", 32'(fail_vec), 32'd0);
    rst_n = 1'b1;

    // start with abort held: abort wins, stay idle
    @(negedge clk);
    start = 1'b1; abort = 1'b1;
    @(negedge clk);
    start = 1'b0; abort = 1'b0;
    chk("sa_idle", 32'(in_ready), 32'd0);

    go();
    chk("run_ready", 32'(in_ready), 32'd1);
    chk("run_busy", 32'(busy), 32'd1);

    // 3+5 with no carry
    xfer(9, 3, 5, 1, 0, 0);
    f = 4'h8; a_eq_b = 1'b0; cn_4 = 1'b1;
    drain();
    chk("d1_err", 32'(err_cnt), 32'd0);
    chk("d1_txn", 32'(txn_cnt), 32'd1);

    // F+1+carry overflows to 0x11
    xfer(9, 15, 1, 0, 0, 0);
    drain();
    chk("d2_err", 32'(err_cnt), 32'd0);
    chk("d2_c4", 32'(ref181(9, 15, 1, 0, 0)), 32'h04);

    // XOR with a wrong observed F captures first failure
    @(negedge clk);
    s = 4'h6; m = 1'b1; cn = 1'b1; a = 4'hA; b = 4'h5;
    f = 4'h0; a_eq_b = 1'b0; cn_4 = 1'b1;
    in_valid = 1'b1;
    @(posedge clk);
    drain();
    chk("d3_err", 32'(err_cnt), 32'd1);
    chk("d3_vec", 32'(fail_vec),
        32'({4'h6, 1'b1, 1'b1, 4'hA, 4'h5, 4'h0, 1'b0, 1'b1}));

    // random traffic with occasional corrupted responses
    m_txn  = 3;
    m_err  = 1;
    m_fail = {4'h6, 1'b1, 1'b1, 4'hA, 4'h5, 4'h0, 1'b0, 1'b1};
    for (int i = 0; i < 300; i++)
      xfer($urandom_range(0, 15), $urandom_range(0, 15),
           $urandom_range(0, 15), $urandom_range(0, 1),
           $urandom_range(0, 1), $urandom_range(0, 3) == 0);
    drain();
    chk_model("rnd");
    do_abort();
    wait_done("rnd_done");
    chk("rnd_pass", 32'(pass), 32'd0);
    chk("rnd_ready", 32'(in_ready), 32'd0);

    // clean run of 10, abort, restart clears everything
    go();
    chk_model("clr1");
    for (int i = 0; i < 10; i++)
      xfer($urandom_range(0, 15), $urandom_range(0, 15),
           $urandom_range(0, 15), $urandom_range(0, 1),
           $urandom_range(0, 1), 0);
    do_abort();
    wait_done("ab_done");
    chk("ab_pass", 32'(pass), 32'd1);
    chk("ab_txn", 32'(txn_cnt), 32'd10);
    go();
    chk_model("clr2");
    chk("re_ready", 32'(in_ready), 32'd1);

    // full sweep with a correct ALU
    for (int vs = 0; vs < 16; vs++)
      for (int vm = 0; vm < 2; vm++)
        for (int va = 0; va < 16; va++)
          for (int vb = 0; vb < 16; vb++)
            for (int vc = 0; vc < 2; vc++)
              xfer(vs, va, vb, vc, vm, 0);
    xfer(0, 0, 0, 0, 1, 1);
    drain();
    wait_done("sw_done");
    chk("sw_pass", 32'(pass), 32'd1);
    chk("sw_txn", 32'(txn_cnt), 32'd16384);
    chk("sw_ready", 32'(in_ready), 32'd0);
    chk_model("sw");

    // reset while a bad compare is in flight
    go();
    xfer(6, 10, 5, 1, 1, 1);
    #1;
    rst_n = 1'b0;
    in_valid = 1'b0;
    #1;
    chk("mr_busy", 32'(busy), 32'd0);
    chk("mr_err", 32'(err_cnt), 32'd0);
    chk("mr_txn", 32'(txn_cnt), 32'd0);
    chk("mr_ready", 32'(in_ready), 32'd0);
    @(negedge clk);
    rst_n = 1'b1;
    @(negedge clk);
    @(negedge clk);
    chk("mr_err2", 32'(err_cnt), 32'd0);
    chk("mr_vec", 32'(fail_vec), 32'd0);
    chk("mr_idle", 32'(in_ready), 32'd0);
    chk("mr_done", 32'(done), 32'd0);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
